// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment scanner with anti-ghost blanking
// Optional blink support is compiled in with `define SEVSEG_BLINK_EN.
module seven_seg_scan #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_SCANS  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  digitsToDisplay,
   input  logic        storageFull,
   input  logic        blink,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   snap_dig_q;
   logic [3:0]    snap_en_q;
   logic          snap_sf_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   logic          wrap;
   logic          lit;
   logic          blink_dark;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;

   always_comb begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
      nib   = snap_dig_q[{idx_q, 2'b00} +: 4];
      lit   = (cnt_q >= CNT_BLANK) && snap_en_q[idx_q] && !blink_dark;
      case (nib)
         4'h0:    seg_dec = 7'b1000000;
         4'h1:    seg_dec = 7'b1111001;
         4'h2:    seg_dec = 7'b0100100;
         4'h3:    seg_dec = 7'b0110000;
         4'h4:    seg_dec = 7'b0011001;
         4'h5:    seg_dec = 7'b0010010;
         4'h6:    seg_dec = 7'b0000010;
         4'h7:    seg_dec = 7'b1111000;
         4'h8:    seg_dec = 7'b0000000;
         4'h9:    seg_dec = 7'b0010000;
         4'hA:    seg_dec = 7'b0001000;
         4'hB:    seg_dec = 7'b0000011;
         4'hC:    seg_dec = 7'b1000110;
         4'hD:    seg_dec = 7'b0100001;
         4'hE:    seg_dec = 7'b0000110;
         default: seg_dec = 7'b0001110;
      endcase
   end

`ifdef SEVSEG_BLINK_EN
   localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

   logic [SW-1:0] scan_q;
   logic          phase_q;

   // A scan completes when the last slot of digit 3 wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_q  <= '0;
         phase_q <= 1'b0;
      end else if (wrap && idx_q == 2'd3) begin
         if (scan_q == SCAN_LAST) begin
            scan_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            scan_q <= scan_q + 1'b1;
         end
      end
   end

   assign blink_dark = blink & phase_q;
`else
   localparam int unused_blink_scans = BLINK_SCANS;
   logic unused_blink;
   assign unused_blink = blink;
   assign blink_dark   = 1'b0;
`endif

   // Inputs are sampled only at the start of a scan so a scan never mixes old and new digits.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         snap_dig_q <= 16'h0000;
         snap_en_q  <= 4'h0;
         snap_sf_q  <= 1'b0;
         an_q       <= 4'hF;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (cnt_q == '0 && idx_q == 2'd0) begin
            snap_dig_q <= digits;
            snap_en_q  <= digitsToDisplay;
            snap_sf_q  <= storageFull;
         end
         an_q  <= lit ? ~(4'b0001 << idx_q) : 4'hF;
         seg_q <= lit ? seg_dec : 7'h7F;
         dp_q  <= !(lit && idx_q == 2'd0 && snap_sf_q);
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - directed self-checking bench for seven_seg_scan
module tb_seven_seg_scan;

   localparam int RD = 8;
   localparam int BC = 2;
   localparam int BS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  digitsToDisplay = 4'h0;
   logic        storageFull = 1'b0;
   logic        blink = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int nchecks = 0;
   int nerrors = 0;
   int k = 0;
   logic [6:0] seg_tbl [16];

   seven_seg_scan #(
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC),
      .BLINK_SCANS (BS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .digits         (digits),
      .digitsToDisplay(digitsToDisplay),
      .storageFull    (storageFull),
      .blink          (blink),
      .an             (an),
      .seg            (seg),
      .dp             (dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sample k is taken at the falling edge after the k-th rising edge since reset release.
   task automatic run(input string tag, input int n, input logic [15:0] dexp,
                      input logic [3:0] enx, input logic sfx, input logic blinkx);
      int c, i, s;
      logic dark, lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         k++;
         c = (k - 1) % RD;
         i = ((k - 1) / RD) % 4;
         s = (k - 1) / (4 * RD);
         dark = 1'b0;
`ifdef SEVSEG_BLINK_EN
         dark = blinkx && ((s / BS) % 2 == 1);
`else
         dark = blinkx && 1'b0;
`endif
         lit   = (c >= BC) && enx[i] && !dark;
         e_an  = lit ? ~(4'b0001 << i) : 4'hF;
         e_seg = lit ? seg_tbl[dexp[4*i +: 4]] : 7'h7F;
         e_dp  = !(lit && i == 0 && sfx);
         check($sformatf("%s.an@%0d", tag, k), {12'h0, an}, {12'h0, e_an});
         check($sformatf("%s.seg@%0d", tag, k), {9'h0, seg}, {9'h0, e_seg});
         check($sformatf("%s.dp@%0d", tag, k), {15'h0, dp}, {15'h0, e_dp});
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check({tag, ".rst_an"}, {12'h0, an}, 16'h000F);
      check({tag, ".rst_seg"}, {9'h0, seg}, 16'h007F);
      check({tag, ".rst_dp"}, {15'h0, dp}, 16'h0001);
      reset = 1'b0;
      k = 0;
   endtask

   initial begin
      seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
      seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
      seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
      seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
      seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
      seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
      seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
      seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;

      digits = 16'h1234; digitsToDisplay = 4'hF; storageFull = 1'b0; blink = 1'b0;
      do_reset("basic");
      run("basic", 64, 16'h1234, 4'hF, 1'b0, 1'b0);

      digits = 16'hFEDC; storageFull = 1'b1;
      do_reset("dp");
      run("dp", 32, 16'hFEDC, 4'hF, 1'b1, 1'b0);

      digits = 16'hACE0; digitsToDisplay = 4'b1000; storageFull = 1'b0;
      do_reset("single");
      run("single", 32, 16'hACE0, 4'b1000, 1'b0, 1'b0);

      digits = 16'hB987; digitsToDisplay = 4'b0000;
      do_reset("none");
      run("none", 32, 16'hB987, 4'b0000, 1'b0, 1'b0);

      digits = 16'h1234; digitsToDisplay = 4'hF;
      do_reset("tear");
      run("tear_a", 12, 16'h1234, 4'hF, 1'b0, 1'b0);
      digits = 16'h5678;
      run("tear_b", 20, 16'h1234, 4'hF, 1'b0, 1'b0);
      run("tear_c", 32, 16'h5678, 4'hF, 1'b0, 1'b0);

      digits = 16'h1234; storageFull = 1'b1;
      do_reset("abort");
      run("abort_pre", 21, 16'h1234, 4'hF, 1'b1, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("abort.an", {12'h0, an}, 16'h000F);
      check("abort.seg", {9'h0, seg}, 16'h007F);
      check("abort.dp", {15'h0, dp}, 16'h0001);
      reset = 1'b0;
      k = 0;
      run("abort_post", 12, 16'h1234, 4'hF, 1'b1, 1'b0);

      digits = 16'h9A0F; storageFull = 1'b0; blink = 1'b1;
      do_reset("blink");
      run("blink", 128, 16'h9A0F, 4'hF, 1'b0, 1'b1);
      blink = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (legal range >= 4).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, meaning anti-ghost dark cycles at the start of each slot (legal range 1..REFRESH_DIV-1).
REQ-003 The block SHALL have parameter BLINK_SCANS, default 64, meaning full scans per blink half-period (legal range >= 1).
REQ-004 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port digits  input  16  four hex nibbles; nibble k = digits[4k+3:4k]; nibble 3 is the leftmost digit.
REQ-007 The block SHALL have port digitsToDisplay  input  4  per-digit enable; bit k enables nibble k.
REQ-008 The block SHALL have port storageFull  input  1  lights the decimal point of digit 0 when high.
REQ-009 The block SHALL have port blink  input  1  blink request; used only per REQ-024/025.
REQ-010 The block SHALL have port an  output  4  anode selects, active-low, one-hot-low or all-high.
REQ-011 The block SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 The block SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-013 The slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; digit index idx (2 bits) SHALL increment mod 4 on each cnt wrap.
REQ-014 The block SHALL snapshot {digits, digitsToDisplay, storageFull} on every edge where cnt==0 and idx==0; input changes at any other time SHALL NOT affect the display until the next snapshot (no mid-scan tearing).
REQ-015 Slot "lit" SHALL mean cnt>=BLANK_CYCLES and snapshot enable bit idx is 1 and the block is not blink-dark.
REQ-016 The block SHALL register outputs from the current (cnt, idx, snapshot); outputs lag counter state by exactly one cycle.
REQ-017 When lit, an SHALL have only bit idx low, and seg SHALL be decode(snapshot nibble idx); otherwise an SHALL be 4'b1111 and seg 7'b1111111.
REQ-018 The decode ({g..a}, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 dp SHALL be 0 only when lit, idx==0 and snapshot storageFull is 1; otherwise 1.
REQ-020 Per slot the block SHALL show exactly BLANK_CYCLES dark cycles then REFRESH_DIV-BLANK_CYCLES lit cycles (if enabled); full scan period SHALL be 4*REFRESH_DIV cycles.
REQ-021 With digitsToDisplay==0 the block SHALL hold an=1111 permanently while counters keep running.

Reset
REQ-022 On reset, at the next edge cnt=0, idx=0, scan counter=0, blink phase=0, snapshot=0, an=4'b1111, seg=7'b1111111, dp=1; reset asserted mid-slot SHALL abort the slot with no partial output.
REQ-023 The first snapshot SHALL occur on the first edge after reset deasserts (cnt==0, idx==0).

Configuration
REQ-024 With SEVSEG_BLINK_EN defined, a scan counter SHALL count completed scans (cnt wrap with idx==3), toggle blink phase every BLINK_SCANS scans, and the block SHALL be blink-dark when blink==1 and phase==1.
REQ-025 Without SEVSEG_BLINK_EN, the blink port SHALL remain present but be ignored, no scan/phase registers SHALL exist, and the block SHALL never be blink-dark.

Verification (bench uses REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_SCANS=2)
REQ-026 Reset, digits=16'h1234, enables=4'b1111 -> per slot 2 cycles an=1111 then 6 cycles: an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001, repeating every 32 cycles.
REQ-027 digits=16'hACE0, enables=4'b1000 -> only an=0111 with seg=0001000 for 6 of every 32 cycles; an=1111 otherwise.
REQ-028 digits changed 16'h1234->16'h5678 during idx==1 -> remainder of scan shows 1,2; next scan shows 8,7,6,5.
REQ-029 storageFull=1, enables=4'b1111 -> dp=0 exactly during the 6 lit cycles of an=1110, dp=1 elsewhere.
REQ-030 Reset asserted at cnt==5 of idx==2 -> next edge an=1111, seg=1111111, dp=1; slot 0 restarts after release.
REQ-031 blink=1 with SEVSEG_BLINK_EN -> scans 0-1 lit, scans 2-3 all an=1111, repeating; without macro all scans lit.
